// File: rtl/remote_bus_arbiter_if.sv
// Bundle of the per-core remote ports and the single slave port.
// master: arbiter view; slave: cores + memory (environment) view.
interface remote_bus_arbiter_if #(
  parameter int NUM_CORES = 4
);
  logic [16*NUM_CORES-1:0] core_addr;
  logic [NUM_CORES-1:0]    core_wren;
  logic [NUM_CORES-1:0]    core_rden;
  logic [16*NUM_CORES-1:0] core_write_val;
  logic [NUM_CORES-1:0]    core_ready;
  logic [15:0]             core_read_val;
  logic [15:0]             mem_addr;
  logic                    mem_wren;
  logic                    mem_rden;
  logic [15:0]             mem_write_val;
  logic                    mem_ready;
  logic [15:0]             mem_read_val;

  modport master (
    input  core_addr, core_wren, core_rden,
    input  core_write_val, mem_ready, mem_read_val,
    output core_ready, core_read_val,
    output mem_addr, mem_wren, mem_rden, mem_write_val
  );

  modport slave (
    output core_addr, core_wren, core_rden,
    output core_write_val, mem_ready, mem_read_val,
    input  core_ready, core_read_val,
    input  mem_addr, mem_wren, mem_rden, mem_write_val
  );
endinterface

// File: rtl/remote_bus_arbiter.sv
// Round-robin arbiter sharing one remote slave bus among NUM_CORES cores.
// Ports: clk, reset (sync, active-low), bus (remote_bus_arbiter_if.master).
module remote_bus_arbiter #(
  parameter int NUM_CORES = 4,
  localparam int ID_WIDTH =
    (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
  input  logic clk,
  input  logic reset,
  remote_bus_arbiter_if.master bus
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  state_e state_q, state_d;
  logic [ID_WIDTH-1:0] grant_q, grant_d;
  logic [ID_WIDTH-1:0] last_q, last_d;

  logic [NUM_CORES-1:0] req;
  logic [ID_WIDTH-1:0]  winner;
  logic                 found;
  logic                 done;

  assign req = bus.core_wren | bus.core_rden;

  // First requester after last_q, wrapping at NUM_CORES-1.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    for (int k = 1; k <= NUM_CORES; k++) begin
      if (!found && req[(int'(last_q) + k) % NUM_CORES]) begin
        found  = 1'b1;
        winner = ID_WIDTH'((int'(last_q) + k) % NUM_CORES);
      end
    end
  end

  // Leave BUSY on accept, or when the owner withdraws its strobes.
  assign done = !req[grant_q] || bus.mem_ready;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= ID_WIDTH'(NUM_CORES - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          state_d = BUSY;
          grant_d = winner;
        end
      end
      BUSY: begin
        if (done) begin
          state_d = IDLE;
          last_d  = grant_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.mem_addr      = '0;
    bus.mem_write_val = '0;
    bus.mem_wren      = 1'b0;
    bus.mem_rden      = 1'b0;
    bus.core_ready    = '0;
    if (state_q == BUSY) begin
      bus.mem_addr      =
        bus.core_addr[{grant_q, 4'b0000} +: 16];
      bus.mem_write_val =
        bus.core_write_val[{grant_q, 4'b0000} +: 16];
      bus.mem_wren      = bus.core_wren[grant_q];
      bus.mem_rden      = bus.core_rden[grant_q];
      bus.core_ready[grant_q] =
        bus.mem_ready & req[grant_q];
    end
  end

  assign bus.core_read_val = bus.mem_read_val;

endmodule

// File: tb/tb_remote_bus_arbiter.sv
// Self-checking bench for remote_bus_arbiter.
// Directed scenarios plus randomized traffic against a queue-free model.
module tb_remote_bus_arbiter;
  localparam int N = 4;
  localparam int W = 16 + 1 + 1 + 16 + N + 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  remote_bus_arbiter_if #(.NUM_CORES(N)) bus ();

  remote_bus_arbiter #(.NUM_CORES(N)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  logic [15:0] ca[N];
  logic [15:0] cd[N];
  logic        cw[N];
  logic        cr[N];
  logic        mrdy;
  logic [15:0] mrv;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      bus.core_addr[16*i +: 16]      = ca[i];
      bus.core_write_val[16*i +: 16] = cd[i];
      bus.core_wren[i]               = cw[i];
      bus.core_rden[i]               = cr[i];
    end
    bus.mem_ready    = mrdy;
    bus.mem_read_val = mrv;
  end

  int checks = 0;
  int errors = 0;

  // Model: own = core currently owning the bus (-1 = nobody).
  int own;
  int lst;
  int ended;
  logic ended_ack;

  function automatic logic rq(int i);
    return cw[i] | cr[i];
  endfunction

  function automatic logic [W-1:0] mexp();
    logic [15:0] a = '0;
    logic [15:0] d = '0;
    logic w = 1'b0;
    logic r = 1'b0;
    logic [N-1:0] rd = '0;
    if (own >= 0) begin
      a = ca[own];
      d = cd[own];
      w = cw[own];
      r = cr[own];
      rd[own] = mrdy & rq(own);
    end
    return {a, w, r, d, rd, mrv};
  endfunction

  function automatic logic [W-1:0] dvec();
    return {bus.mem_addr, bus.mem_wren, bus.mem_rden,
            bus.mem_write_val, bus.core_ready,
            bus.core_read_val};
  endfunction

  function automatic logic [N-1:0] macc();
    logic [W-1:0] v = mexp();
    return v[N+15:16];
  endfunction

  task automatic tick();
    @(posedge clk);
    ended = -1;
    ended_ack = 1'b0;
    if (!reset) begin
      own = -1;
      lst = N - 1;
    end else if (own < 0) begin
      for (int k = 1; k <= N; k++)
        if (own < 0 && rq((lst + k) % N)) own = (lst + k) % N;
    end else if (!rq(own) || mrdy) begin
      ended = own;
      ended_ack = rq(own) && mrdy;
      lst = own;
      own = -1;
    end
    #1;
  endtask

  task automatic clear_reqs();
    for (int i = 0; i < N; i++) begin
      cw[i] = 1'b0;
      cr[i] = 1'b0;
      ca[i] = 16'($urandom);
      cd[i] = 16'($urandom);
    end
  endtask

  task automatic do_reset();
    clear_reqs();
    mrdy  = 1'b0;
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    for (int i = 0; i < N; i++) cw[i] = 1'b1;
    mrdy = 1'b1;
    tick();
    for (int c = 0; c < 3; c++) begin
      mrv = 16'($urandom);
      @(negedge clk);
      checks++;
      if (dvec() !== {34'b0, {N{1'b0}}, mrv}) begin
        errors++;
        $display("FAIL reset_outputs c=%0d got=%h exp=%h",
                 c, dvec(), {34'b0, {N{1'b0}}, mrv});
      end
      tick();
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.mem_wren !== 1'b0 || bus.core_ready !== '0) begin
      errors++;
      $display("FAIL reset_bubble got wren=%b ready=%b exp 0/0",
               bus.mem_wren, bus.core_ready);
    end
    tick();
    @(negedge clk);
    checks++;
    if (bus.core_ready !== 4'b0001 || bus.mem_addr !== ca[0]) begin
      errors++;
      $display("FAIL reset_first_core0 got ready=%b addr=%h exp 0001/%h",
               bus.core_ready, bus.mem_addr, ca[0]);
    end
    tick();
  endtask

  task automatic test_single_read();
    do_reset();
    cr[2] = 1'b1;
    ca[2] = 16'h8000;
    mrdy  = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.mem_rden !== 1'b0 || dvec() !== mexp()) begin
      errors++;
      $display("FAIL t1_cycleN got=%h exp=%h", dvec(), mexp());
    end
    tick();
    @(negedge clk);
    checks++;
    if (bus.mem_rden !== 1'b1 || bus.mem_addr !== 16'h8000 ||
        bus.core_ready !== 4'b0100 || dvec() !== mexp()) begin
      errors++;
      $display("FAIL t1_strobe got rden=%b addr=%h ready=%b exp 1/8000/0100",
               bus.mem_rden, bus.mem_addr, bus.core_ready);
    end
    tick();
    cr[2] = 1'b0;
    mrv   = 16'h1234;
    @(negedge clk);
    checks++;
    if (bus.core_read_val !== 16'h1234 || dvec() !== mexp()) begin
      errors++;
      $display("FAIL t1_read_val got=%h exp=1234", bus.core_read_val);
    end
    tick();
  endtask

  task automatic test_all_writes();
    int qc[$];
    logic [15:0] qd[$];
    logic [N-1:0] acc;
    do_reset();
    for (int i = 0; i < N; i++) begin
      cw[i] = 1'b1;
      cd[i] = 16'(8'hA0 + i);
    end
    mrdy = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      checks++;
      if (dvec() !== mexp()) begin
        errors++;
        $display("FAIL t2_model c=%0d got=%h exp=%h", c, dvec(), mexp());
      end
      if (bus.core_ready !== '0) begin
        qc.push_back(c);
        qd.push_back(bus.mem_write_val);
      end
      acc = macc();
      tick();
      for (int i = 0; i < N; i++) if (acc[i]) cw[i] = 1'b0;
    end
    checks++;
    if (qc.size() != N) begin
      errors++;
      $display("FAIL t2_count got=%0d exp=%0d", qc.size(), N);
    end
    for (int i = 0; i < N && i < qc.size(); i++) begin
      checks++;
      if (qd[i] !== 16'(8'hA0 + i) || qc[i] != 2 * i + 1) begin
        errors++;
        $display("FAIL t2_order i=%0d got data=%h cyc=%0d exp %h/%0d",
                 i, qd[i], qc[i], 16'(8'hA0 + i), 2 * i + 1);
      end
    end
  endtask

  task automatic test_wait_states();
    do_reset();
    cw[1] = 1'b1;
    mrdy  = 1'b0;
    @(negedge clk);
    tick();
    for (int c = 1; c <= 4; c++) begin
      if (c == 4) mrdy = 1'b1;
      @(negedge clk);
      checks++;
      if (bus.mem_addr !== ca[1] || bus.mem_write_val !== cd[1] ||
          bus.mem_wren !== 1'b1 ||
          bus.core_ready !== ((c == 4) ? 4'b0010 : 4'b0000) ||
          dvec() !== mexp()) begin
        errors++;
        $display("FAIL t3_wait c=%0d got=%h exp=%h", c, dvec(), mexp());
      end
      tick();
    end
    cw[1] = 1'b0;
  endtask

  task automatic test_back_to_back();
    int gq[$];
    logic [N-1:0] acc;
    do_reset();
    cw[1] = 1'b1;
    cr[3] = 1'b1;
    mrdy  = 1'b1;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      checks++;
      if (dvec() !== mexp()) begin
        errors++;
        $display("FAIL t4_model c=%0d got=%h exp=%h", c, dvec(), mexp());
      end
      for (int i = 0; i < N; i++)
        if (bus.core_ready[i]) gq.push_back(i);
      acc = macc();
      tick();
      for (int i = 0; i < N; i++)
        if (acc[i]) ca[i] = 16'($urandom);
    end
    checks++;
    if (gq.size() < 4) begin
      errors++;
      $display("FAIL t4_grants got=%0d exp>=4", gq.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (gq[i] != ((i % 2 == 0) ? 1 : 3)) begin
          errors++;
          $display("FAIL t4_alt i=%0d got=%0d exp=%0d",
                   i, gq[i], (i % 2 == 0) ? 1 : 3);
        end
      end
    end
    for (int i = 1; i < gq.size(); i++) begin
      checks++;
      if (gq[i] == gq[i-1]) begin
        errors++;
        $display("FAIL t4_repeat i=%0d got=%0d exp!=%0d", i, gq[i], gq[i-1]);
      end
    end
  endtask

  task automatic test_reset_mid_access();
    do_reset();
    cw[1] = 1'b1;
    mrdy  = 1'b0;
    @(negedge clk);
    tick();
    @(negedge clk);
    checks++;
    if (bus.mem_wren !== 1'b1 || dvec() !== mexp()) begin
      errors++;
      $display("FAIL t5_busy got=%h exp=%h", dvec(), mexp());
    end
    tick();
    reset = 1'b0;
    @(negedge clk);
    tick();
    reset = 1'b1;
    cw[1] = 1'b0;
    cw[0] = 1'b1;
    cw[2] = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.mem_wren !== 1'b0 || bus.mem_rden !== 1'b0 ||
        bus.core_ready !== '0 || dvec() !== mexp()) begin
      errors++;
      $display("FAIL t5_after_reset got=%h exp=%h", dvec(), mexp());
    end
    tick();
    @(negedge clk);
    checks++;
    if (bus.mem_addr !== ca[0] || bus.mem_wren !== 1'b1 ||
        dvec() !== mexp()) begin
      errors++;
      $display("FAIL t5_core0_first got addr=%h exp=%h",
               bus.mem_addr, ca[0]);
    end
    tick();
  endtask

  task automatic test_drop_request();
    do_reset();
    cr[2] = 1'b1;
    mrdy  = 1'b0;
    @(negedge clk);
    tick();
    cr[2] = 1'b0;
    cw[0] = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++;
      if (bus.core_ready !== '0 || dvec() !== mexp()) begin
        errors++;
        $display("FAIL t6_drop c=%0d got=%h exp=%h", c, dvec(), mexp());
      end
      tick();
    end
    mrdy = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.core_ready !== 4'b0001 || bus.mem_addr !== ca[0]) begin
      errors++;
      $display("FAIL t6_next got ready=%b addr=%h exp 0001/%h",
               bus.core_ready, bus.mem_addr, ca[0]);
    end
    tick();
  endtask

  task automatic test_random();
    int wt[N];
    logic [N-1:0] acc;
    do_reset();
    for (int i = 0; i < N; i++) wt[i] = 0;
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      checks++;
      if (dvec() !== mexp()) begin
        errors++;
        $display("FAIL rnd_model c=%0d got=%h exp=%h", c, dvec(), mexp());
      end
      acc = macc();
      tick();
      if (ended >= 0) begin
        if (ended_ack) begin
          checks++;
          if (wt[ended] > N - 1) begin
            errors++;
            $display("FAIL rnd_fair core=%0d got=%0d exp<=%0d",
                     ended, wt[ended], N - 1);
          end
        end
        wt[ended] = 0;
        for (int i = 0; i < N; i++)
          if (i != ended && rq(i)) wt[i]++;
      end
      reset = ($urandom_range(0, 199) != 0);
      if (!reset) for (int i = 0; i < N; i++) wt[i] = 0;
      for (int i = 0; i < N; i++) begin
        if (acc[i] || !rq(i)) begin
          cw[i] = 1'b0;
          cr[i] = 1'b0;
          wt[i] = 0;
          if ($urandom_range(0, 2) == 0) begin
            logic [1:0] s;
            s = 2'($urandom_range(1, 3));
            cw[i] = s[0];
            cr[i] = s[1];
            ca[i] = 16'($urandom);
            cd[i] = 16'($urandom);
          end
        end else if ($urandom_range(0, 49) == 0) begin
          cw[i] = 1'b0;
          cr[i] = 1'b0;
          wt[i] = 0;
        end
      end
      mrdy = ($urandom_range(0, 2) != 0);
      mrv  = 16'($urandom);
    end
  endtask

  initial begin
    own   = -1;
    lst   = N - 1;
    reset = 1'b0;
    mrdy  = 1'b0;
    mrv   = '0;
    clear_reqs();
    tick();
    test_reset();
    test_single_read();
    test_all_writes();
    test_wait_states();
    test_back_to_back();
    test_reset_mid_access();
    test_drop_request();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
